// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for the ID/EX stage with valid/ready handshake and mul hold/stall.
// Optional feature: define ALU_ILLEGAL_TRAP_EN to trap unknown R-type Funct codes on Illegal.
module alu_ctrl_seq #(
   parameter int OP_W       = 6,
   parameter int FUNCT_W    = 6,
   parameter int SEL_W      = 6,
   parameter int MUL_CYCLES = 3
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               InValid,
   output logic               InReady,
   input  logic [OP_W-1:0]    ALUOp,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic               Flush,
   output logic               OutValid,
   output logic [SEL_W-1:0]   ALUSel,
   output logic               Stall,
   output logic               Illegal
);

   localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
   localparam logic [SEL_W-1:0] SEL_MUL = SEL_W'(3);

   typedef enum logic [1:0] {IDLE, ISSUE, MULW} state_t;

   typedef struct packed {
      logic             ill;
      logic             mul;
      logic [SEL_W-1:0] sel;
   } dec_t;

   function automatic dec_t decode(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] fn);
      dec_t d;
      logic [OP_W+SEL_W-1:0] ext;
      d   = '0;
      ext = {{SEL_W{1'b0}}, op};
      if (op != '0) begin
         d.sel = ext[SEL_W-1:0];
      end else begin
         case (fn)
            FUNCT_W'(6'b100000): d.sel = SEL_W'(0);
            FUNCT_W'(6'b100010): d.sel = SEL_W'(2);
            FUNCT_W'(6'b011000): begin
               d.sel = SEL_MUL;
               d.mul = (MUL_CYCLES > 1);
            end
            FUNCT_W'(6'b001000): d.sel = SEL_W'(17);
            FUNCT_W'(6'b100100): d.sel = SEL_W'(19);
            FUNCT_W'(6'b100101): d.sel = SEL_W'(21);
            FUNCT_W'(6'b100111): d.sel = SEL_W'(22);
            FUNCT_W'(6'b100110): d.sel = SEL_W'(23);
            FUNCT_W'(6'b000000): d.sel = SEL_W'(26);
            FUNCT_W'(6'b000010): d.sel = SEL_W'(27);
            FUNCT_W'(6'b101010): d.sel = SEL_W'(28);
            default: begin
               d.sel = '0;
`ifdef ALU_ILLEGAL_TRAP_EN
               d.ill = 1'b1;
`endif
            end
         endcase
      end
      return d;
   endfunction

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [SEL_W-1:0]  sel_p1;
   logic              vld_p1;
   logic              stall_p1;
   logic              illegal_p1;
   logic              mulp_p1;
   dec_t              dec_p0;
   logic              accept;

   assign dec_p0   = decode(ALUOp, Funct);
   assign InReady  = (state == IDLE) | ((state == ISSUE) & ~mulp_p1);
   assign accept   = InValid & InReady;

   assign OutValid = vld_p1;
   assign ALUSel   = sel_p1;
   assign Stall    = stall_p1;
   assign Illegal  = illegal_p1;

   // decode -> registered select (p0 -> p1)
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         sel_p1     <= '0;
         vld_p1     <= 1'b0;
         stall_p1   <= 1'b0;
         illegal_p1 <= 1'b0;
         mulp_p1    <= 1'b0;
      end else if (Flush) begin
         state      <= IDLE;
         cnt        <= '0;
         sel_p1     <= '0;
         vld_p1     <= 1'b0;
         stall_p1   <= 1'b0;
         illegal_p1 <= 1'b0;
         mulp_p1    <= 1'b0;
      end else begin
         illegal_p1 <= 1'b0;
         case (state)
            IDLE, ISSUE: begin
               if ((state == ISSUE) && mulp_p1) begin
                  state    <= MULW;
                  cnt      <= CNT_W'(MUL_CYCLES - 1);
                  stall_p1 <= 1'b1;
               end else if (accept && dec_p0.ill) begin
                  state      <= IDLE;
                  vld_p1     <= 1'b0;
                  sel_p1     <= '0;
                  illegal_p1 <= 1'b1;
                  mulp_p1    <= 1'b0;
               end else if (accept) begin
                  state   <= ISSUE;
                  vld_p1  <= 1'b1;
                  sel_p1  <= dec_p0.sel;
                  mulp_p1 <= dec_p0.mul;
               end else begin
                  state   <= IDLE;
                  vld_p1  <= 1'b0;
                  mulp_p1 <= 1'b0;
               end
            end
            MULW: begin
               if (cnt == CNT_W'(1)) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  vld_p1   <= 1'b0;
                  stall_p1 <= 1'b0;
                  mulp_p1  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
